fifo_rd_stream: RTL and testbench

- Read-side drain engine for the async FIFO; sits entirely in the read clock domain.
- Issues rd_en to the FIFO while it is non-empty and buffer credit is available.
- Captures the registered read data one cycle later and presents it as a valid/ready stream to downstream logic.
- Hides FIFO read latency behind a small prefetch buffer, sustains 1 word/cycle, and keeps a delivered-word count.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_stream_if.sv | 26 ++
 rtl/fifo_rd_stream_buf.sv | 56 +++++
 rtl/fifo_rd_stream.sv | 61 ++++++
 tb/tb_fifo_rd_stream.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO defaults and a constant clog2 helper for port/counter sizing.
// No logic, no latency, no flow control.
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, grouped for the drain engine.
// master = drain engine side, slave = FIFO/consumer (testbench) side.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

  logic                 fifo_rempty;
  logic                 fifo_rd_en;
  logic [DATA_SIZE-1:0] fifo_rd_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  modport master (
    input  fifo_rempty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_rempty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_rd_stream_buf.sv
// Register circular buffer with push/pop/clear; head word visible combinationally from storage.
// Zero latency; caller must never push when full or pop when empty.
module stream_buf
  import fifo_pkg::*;
#(
  parameter int  DATA_SIZE = DATA_SIZE_DEF,
  parameter int  DEPTH     = 3,
  localparam int PTR_W     = clog2(DEPTH),
  localparam int OCC_W     = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] head_data,
  output logic [OCC_W-1:0]     occ
);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;

  // Explicit compare-and-clear so non-power-of-2 depths wrap correctly.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read side into a valid/ready stream; rd_en to m_valid is 2 cycles, 1 word/cycle sustained.
// Backpressure: credit-based issue, never more reads outstanding than free prefetch slots; m_data holds while stalled.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int  DATA_SIZE = 8,
  parameter int  BUF_DEPTH = 3,
  parameter int  CNT_WIDTH = 32,
  localparam int LVL_W     = clog2(BUF_DEPTH + 1)
) (
  input  logic                 rd_clk,
  input  logic                 rd_rstn,
  fifo_rd_stream_if.master     bus,
  input  logic                 flush,
  output logic [LVL_W-1:0]     buf_level,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  logic             inflight;
  logic             discard;
  logic             has_credit;
  logic             push;
  logic             pop;
  logic [LVL_W-1:0] occ;

  // Credit uses registered state only, so m_ready never reaches fifo_rd_en.
  assign has_credit     = (int'(occ) + int'(inflight)) < BUF_DEPTH;
  assign bus.fifo_rd_en = rd_rstn & ~bus.fifo_rempty & ~flush & has_credit;

  assign push      = inflight & ~discard;
  assign pop       = bus.m_valid & bus.m_ready;
  assign bus.m_valid = (occ != '0);
  assign buf_level = occ;

  stream_buf #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rstn),
    .clear     (flush),
    .push      (push),
    .push_data (bus.fifo_rd_data),
    .pop       (pop),
    .head_data (bus.m_data),
    .occ       (occ)
  );

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      inflight   <= 1'b0;
      discard    <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      discard  <= flush & inflight;
      if (pop) xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO model plus in-order scoreboard of expected stream words.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  logic        rd_clk  = 1'b0;
  logic        rd_rstn = 1'b0;
  logic        flush   = 1'b0;
  logic [1:0]  buf_level, buf_level4;
  logic [31:0] xfer_count;
  logic [3:0]  xfer_count4;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  logic [7:0] junk;
  logic [31:0] exp_xfer = '0;
  bit  hold_empty = 1'b0;
  int  loaded     = 0;
  int  popped     = 0;
  int  delivered  = 0;
  int  rd_pulses  = 0;
  int  n_tests    = 0;
  int  n_fail     = 0;
  int  base, k;

  fifo_rd_stream_if #(.DATA_SIZE(8)) bus ();
  fifo_rd_stream_if #(.DATA_SIZE(8)) bus4 ();

  assign bus.fifo_rempty   = hold_empty || (loaded == popped);
  assign bus4.fifo_rempty  = bus.fifo_rempty;
  assign bus4.fifo_rd_data = bus.fifo_rd_data;
  assign bus4.m_ready      = bus.m_ready;

  fifo_rd_stream #(.DATA_SIZE(8), .BUF_DEPTH(3), .CNT_WIDTH(32)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .bus(bus), .flush(flush),
    .buf_level(buf_level), .xfer_count(xfer_count)
  );

  fifo_rd_stream #(.DATA_SIZE(8), .BUF_DEPTH(3), .CNT_WIDTH(4)) dut4 (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .bus(bus4), .flush(flush),
    .buf_level(buf_level4), .xfer_count(xfer_count4)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model and stream monitor share one edge process so their ordering is fixed.
  always @(posedge rd_clk) begin
    if (!rd_rstn) begin
      delivered = popped;
      exp_xfer  = '0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $error("FAIL spurious_word observed=%0h expected=none", bus.m_data);
        end else begin
          exp_w = exp_q.pop_front();
          assert (bus.m_data === exp_w) else begin
            n_fail++;
            $error("FAIL stream_order observed=%0h expected=%0h", bus.m_data, exp_w);
          end
        end
        delivered++;
        exp_xfer++;
      end
      if (flush) begin
        while (delivered < popped) begin
          if (exp_q.size() != 0) junk = exp_q.pop_front();
          delivered++;
        end
      end
      n_tests++;
      assert ((bus.fifo_rd_en & bus.fifo_rempty) === 1'b0) else begin
        n_fail++;
        $error("FAIL rd_en_while_empty observed=1 expected=0");
      end
      if (bus.fifo_rd_en) begin
        rd_pulses++;
        popped <= popped + 1;
        if (fifo_q.size() != 0) bus.fifo_rd_data <= fifo_q.pop_front();
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + 8'(i));
      exp_q.push_back(first + 8'(i));
    end
    loaded += n;
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge rd_clk);
      c++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_idle"}, bus.m_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_ready = 1'b1;
    load(8'h01, 16);
    repeat (3) @(negedge rd_clk);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_buf_level", buf_level, 0);
    check("rst_xfer_count", xfer_count, 0);

    rd_rstn = 1'b1;
    #1;
    check("first_rd_en", bus.fifo_rd_en, 1);
    @(negedge rd_clk);
    check("valid_lat1", bus.m_valid, 0);
    @(negedge rd_clk);
    check("valid_lat2", bus.m_valid, 1);
    check("first_word", bus.m_data, 8'h01);
    for (int i = 1; i < 16; i++) begin
      @(negedge rd_clk);
      check("no_bubble", bus.m_valid, 1);
      check("stream_cnt", xfer_count, i);
    end
    @(negedge rd_clk);
    check("stream_xfer16", xfer_count, 16);
    check("cnt4_wrap16", xfer_count4, 0);
    check("stream_idle", bus.m_valid, 0);

    bus.m_ready = 1'b0;
    base = rd_pulses;
    load(8'h20, 10);
    repeat (8) @(negedge rd_clk);
    check("bp_pulses", rd_pulses - base, 3);
    check("bp_level", buf_level, 3);
    check("bp_valid", bus.m_valid, 1);
    check("bp_head", bus.m_data, 8'h20);
    @(negedge rd_clk);
    check("bp_hold", bus.m_data, 8'h20);
    check("bp_xfer", xfer_count, 16);
    bus.m_ready = 1'b1;
    drain("bp_drain", 40);
    check("bp_xfer_done", xfer_count, 26);

    load(8'h40, 20);
    for (int c = 0; c < 80; c++) begin
      @(negedge rd_clk);
      if (c % 2 == 0) hold_empty = ~hold_empty;
      bus.m_ready = 1'($urandom_range(0, 1));
    end
    hold_empty  = 1'b0;
    bus.m_ready = 1'b1;
    drain("toggle_drain", 60);
    check("toggle_xfer", xfer_count, 46);

    bus.m_ready = 1'b0;
    load(8'h60, 6);
    repeat (3) @(negedge rd_clk);
    check("pre_flush_level", buf_level, 2);
    flush = 1'b1;
    #1;
    check("flush_rd_en", bus.fifo_rd_en, 0);
    @(negedge rd_clk);
    flush = 1'b0;
    check("flush_valid", bus.m_valid, 0);
    check("flush_level", buf_level, 0);
    check("flush_xfer", xfer_count, 46);
    bus.m_ready = 1'b1;
    k = 0;
    while (!bus.m_valid && k < 10) begin
      @(negedge rd_clk);
      k++;
    end
    check("post_flush_word", bus.m_data, 8'h63);
    drain("flush_drain", 40);
    check("flush_xfer_done", xfer_count, 49);

    @(negedge rd_clk);
    rd_rstn = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    loaded = popped;
    @(negedge rd_clk);
    check("wrap_rst", xfer_count4, 0);
    load(8'h80, 17);
    rd_rstn = 1'b1;
    k = 0;
    while (exp_xfer != 15 && k < 40) begin
      @(negedge rd_clk);
      k++;
    end
    check("wrap_15", xfer_count4, 15);
    @(negedge rd_clk);
    check("wrap_0", xfer_count4, 0);
    @(negedge rd_clk);
    check("wrap_1", xfer_count4, 1);
    check("wrap_wide", xfer_count, 17);
    drain("wrap_drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
